// File: rtl/mod12_wrap_tracker.sv
// Monitor for a mod-12 up/down counter: classifies each sampled transition, keeps a
// saturating signed revolution count and queues notable events toward a valid/ready consumer.
module mod12_wrap_tracker #(
    parameter int DEPTH   = 4,
    parameter int TURNS_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                cnt_in,
    input  logic                      load_in,
    input  logic                      up_down_in,
    output logic signed [TURNS_W-1:0] turns,
    output logic                      err_jump,
    output logic                      err_illegal,
    output logic                      ovf,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [2:0]                evt_code,
    output logic [3:0]                evt_value
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic signed [TURNS_W-1:0] TURNS_MAX = {1'b0, {(TURNS_W - 1) {1'b1}}};
    localparam logic signed [TURNS_W-1:0] TURNS_MIN = {1'b1, {(TURNS_W - 1) {1'b0}}};
    localparam logic signed [TURNS_W-1:0] TURNS_ONE = {{(TURNS_W - 1) {1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        EVT_WRAP_UP   = 3'd0,
        EVT_WRAP_DOWN = 3'd1,
        EVT_LOAD      = 3'd2,
        EVT_JUMP      = 3'd3,
        EVT_ILLEGAL   = 3'd4
    } evt_code_t;

    typedef struct packed {
        evt_code_t  code;
        logic [3:0] value;
    } evt_t;

    logic [3:0] prev;
    logic       prev_valid;

    logic       push;
    evt_t       push_evt;
    logic [3:0] next_prev;
    logic       next_prev_valid;
    logic       turn_inc;
    logic       turn_dec;
    logic       set_jump;
    logic       set_illegal;

    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        push            = 1'b0;
        push_evt.code   = EVT_JUMP;
        push_evt.value  = cnt_in;
        next_prev       = prev;
        next_prev_valid = prev_valid;
        turn_inc        = 1'b0;
        turn_dec        = 1'b0;
        set_jump        = 1'b0;
        set_illegal     = 1'b0;

        if (cnt_in > 4'd11) begin
            push            = 1'b1;
            push_evt.code   = EVT_ILLEGAL;
            set_illegal     = 1'b1;
            next_prev_valid = 1'b0;
        end else begin
            next_prev       = cnt_in;
            next_prev_valid = 1'b1;
            if (!prev_valid) begin
                // first legal sample only primes the tracker
            end else if (load_in) begin
                push          = 1'b1;
                push_evt.code = EVT_LOAD;
            end else if (cnt_in == prev) begin
                // hold
            end else if (up_down_in && prev != 4'd11 && cnt_in == prev + 4'd1) begin
                // step up
            end else if (up_down_in && prev == 4'd11 && cnt_in == 4'd0) begin
                push          = 1'b1;
                push_evt.code = EVT_WRAP_UP;
                turn_inc      = 1'b1;
            end else if (!up_down_in && prev != 4'd0 && cnt_in == prev - 4'd1) begin
                // step down
            end else if (!up_down_in && prev == 4'd0 && cnt_in == 4'd11) begin
                push          = 1'b1;
                push_evt.code = EVT_WRAP_DOWN;
                turn_dec      = 1'b1;
            end else begin
                push          = 1'b1;
                push_evt.code = EVT_JUMP;
                set_jump      = 1'b1;
            end
        end
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    evt_t             mem [DEPTH];
    evt_t             head;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full      = (count == FIFO_FULL);
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);
    assign head      = mem[rd_ptr];
    assign evt_code  = evt_valid ? head.code  : 3'd0;
    assign evt_value = evt_valid ? head.value : 4'd0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev        <= '0;
            prev_valid  <= 1'b0;
            turns       <= '0;
            err_jump    <= 1'b0;
            err_illegal <= 1'b0;
            ovf         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            prev       <= next_prev;
            prev_valid <= next_prev_valid;

            if (turn_inc && turns != TURNS_MAX) begin
                turns <= turns + TURNS_ONE;
            end else if (turn_dec && turns != TURNS_MIN) begin
                turns <= turns - TURNS_ONE;
            end

            if (set_jump) begin
                err_jump <= 1'b1;
            end
            if (set_illegal) begin
                err_illegal <= 1'b1;
            end
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count and the
    // outputs are masked while nothing is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_evt;
        end
    end

endmodule

// File: tb/tb_mod12_wrap_tracker.sv
// Directed bench for mod12_wrap_tracker: table of single-step vectors plus hand-written
// sequences for FIFO overflow, drain order, saturation and mid-stream reset.
module tb_mod12_wrap_tracker;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        cnt_in = '0;
    logic              load_in = 1'b0;
    logic              up_down_in = 1'b1;
    logic signed [7:0] turns;
    logic              err_jump;
    logic              err_illegal;
    logic              ovf;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [2:0]        evt_code;
    logic [3:0]        evt_value;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] C_WUP = 3'd0, C_WDN = 3'd1, C_LOAD = 3'd2, C_JUMP = 3'd3, C_ILL = 3'd4;

    mod12_wrap_tracker #(.DEPTH(4), .TURNS_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .load_in    (load_in),
        .up_down_in (up_down_in),
        .turns      (turns),
        .err_jump   (err_jump),
        .err_illegal(err_illegal),
        .ovf        (ovf),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_value  (evt_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic [3:0] cnt;
        logic       load;
        logic       up;
        logic       ready;
        logic [7:0] exp_turns;
        logic       exp_jump;
        logic       exp_ill;
        logic       exp_ovf;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [3:0] exp_value;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [3:0] c, input logic l, input logic u,
                               input logic [7:0] t, input logic j, input logic i,
                               input logic val, input logic [2:0] code, input logic [3:0] value);
        vec_t x;
        x.rst_first = r;  x.cnt = c;  x.load = l;  x.up = u;  x.ready = 1'b1;
        x.exp_turns = t;  x.exp_jump = j;  x.exp_ill = i;  x.exp_ovf = 1'b0;
        x.exp_valid = val;  x.exp_code = code;  x.exp_value = value;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic l, input logic u, input logic r);
        cnt_in     = c;
        load_in    = l;
        up_down_in = u;
        evt_ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic val, input logic [2:0] code,
                              input logic [3:0] value);
        check({name, "_valid"}, 32'(evt_valid), 32'(val));
        if (val) begin
            check({name, "_code"}, 32'(evt_code), 32'(code));
            check({name, "_value"}, 32'(evt_value), 32'(value));
        end
    endtask

    // Reset is asserted between edges; outputs must clear before any clock arrives.
    task automatic do_reset(input string name);
        rst = 1'b0;
        #2;
        check({name, "_turns"}, 32'($unsigned(turns)), 32'd0);
        check({name, "_valid"}, 32'(evt_valid), 32'd0);
        check({name, "_flags"}, {29'd0, err_jump, err_illegal, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Prime and count up through 11 -> 0.
        vecs.push_back(v(1, 9,  0, 1, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 10, 0, 1, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 11, 0, 1, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0, 1, 8'd1,   0, 0, 1, C_WUP, 0));
        vecs.push_back(v(0, 1,  0, 1, 8'd1,   0, 0, 0, 0, 0));
        // Count down across zero.
        vecs.push_back(v(1, 1,  0, 0, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0, 0, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 11, 0, 0, 8'hFF,  0, 0, 1, C_WDN, 11));
        vecs.push_back(v(0, 10, 0, 0, 8'hFF,  0, 0, 0, 0, 0));
        // Load, jump, load that matches a step, jump downward.
        vecs.push_back(v(1, 3,  0, 1, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 7,  1, 1, 8'd0,   0, 0, 1, C_LOAD, 7));
        vecs.push_back(v(0, 2,  0, 1, 8'd0,   1, 0, 1, C_JUMP, 2));
        vecs.push_back(v(0, 3,  0, 1, 8'd0,   1, 0, 0, 0, 0));
        vecs.push_back(v(0, 4,  1, 1, 8'd0,   1, 0, 1, C_LOAD, 4));
        vecs.push_back(v(0, 1,  0, 0, 8'd0,   1, 0, 1, C_JUMP, 1));
        vecs.push_back(v(0, 0,  0, 0, 8'd0,   1, 0, 0, 0, 0));
        // Illegal values re-prime the tracker; illegal outranks load.
        vecs.push_back(v(1, 5,  0, 1, 8'd0,   0, 0, 0, 0, 0));
        vecs.push_back(v(0, 13, 0, 1, 8'd0,   0, 1, 1, C_ILL, 13));
        vecs.push_back(v(0, 0,  0, 1, 8'd0,   0, 1, 0, 0, 0));
        vecs.push_back(v(0, 1,  0, 1, 8'd0,   0, 1, 0, 0, 0));
        vecs.push_back(v(0, 14, 1, 1, 8'd0,   0, 1, 1, C_ILL, 14));
        vecs.push_back(v(0, 11, 0, 0, 8'd0,   0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0,  0, 1, 8'd1,   0, 1, 1, C_WUP, 0));

        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst_first) begin
                do_reset($sformatf("vec%0d_rst", i));
            end
            step(vecs[i].cnt, vecs[i].load, vecs[i].up, vecs[i].ready);
            check($sformatf("vec%0d_turns", i), 32'($unsigned(turns)), 32'(vecs[i].exp_turns));
            check($sformatf("vec%0d_jump", i), 32'(err_jump), 32'(vecs[i].exp_jump));
            check($sformatf("vec%0d_illegal", i), 32'(err_illegal), 32'(vecs[i].exp_ill));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            check_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                       vecs[i].exp_value);
        end

        // FIFO fill, overflow, simultaneous push/pop while full, ordered drain.
        do_reset("ovf_rst");
        step(0, 0, 1, 0);
        step(11, 1, 1, 0);
        step(0, 0, 1, 0);
        step(11, 1, 1, 0);
        step(0, 0, 1, 0);
        check("full_no_ovf", 32'(ovf), 32'd0);
        check_head("full_head", 1'b1, C_LOAD, 4'd11);
        step(11, 1, 1, 0);
        check("ovf_set", 32'(ovf), 32'd1);
        check_head("ovf_head_stable", 1'b1, C_LOAD, 4'd11);
        step(0, 0, 1, 0);
        step(11, 1, 1, 0);
        step(0, 0, 1, 0);
        step(11, 1, 1, 0);
        step(0, 0, 1, 0);
        check("ovf_turns", 32'($unsigned(turns)), 32'd5);
        check("ovf_sticky", 32'(ovf), 32'd1);
        check_head("ovf_head_final", 1'b1, C_LOAD, 4'd11);
        step(5, 1, 1, 1);
        check_head("pushpop_head", 1'b1, C_WUP, 4'd0);
        step(5, 0, 1, 1);
        check_head("drain1", 1'b1, C_LOAD, 4'd11);
        step(5, 0, 1, 1);
        check_head("drain2", 1'b1, C_WUP, 4'd0);
        step(5, 0, 1, 1);
        check_head("drain3", 1'b1, C_LOAD, 4'd5);
        step(5, 0, 1, 1);
        check_head("drain_empty", 1'b0, 3'd0, 4'd0);
        check("drain_turns", 32'($unsigned(turns)), 32'd5);

        // Saturation at +127, then reset mid-stream with prev sitting at 11.
        do_reset("sat_rst");
        step(0, 0, 1, 1);
        for (int w = 1; w <= 130; w++) begin
            for (int k = 1; k <= 11; k++) begin
                step(4'(k), 0, 1, 1);
            end
            step(0, 0, 1, 1);
            if (w == 127) begin
                check("sat_reach", 32'($unsigned(turns)), 32'd127);
            end
        end
        check("sat_hold", 32'($unsigned(turns)), 32'd127);
        check_head("sat_head", 1'b1, C_WUP, 4'd0);
        check("sat_no_err", {29'd0, err_jump, err_illegal, ovf}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            step(4'(k), 0, 1, 1);
        end
        do_reset("mid_rst");
        step(0, 0, 1, 1);
        check_head("post_rst_prime", 1'b0, 3'd0, 4'd0);
        check("post_rst_turns", 32'($unsigned(turns)), 32'd0);
        step(1, 0, 1, 1);
        check_head("post_rst_step", 1'b0, 3'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod12_wrap_tracker.md
# mod12_wrap_tracker

Downstream consumer of the mod-12 loadable up/down counter: samples the counter's dout together with the load/up_down qualifiers each clock, classifies every transition, and keeps a saturating signed count of full revolutions. Notable events (wraps, loads, unexpected jumps, illegal values) are queued in a small FIFO and drained through a valid/ready port toward the scoreboard/checker side of the environment. The block is synthesizable and is also used as a reference monitor.

## Interface

- DEPTH, 4: event FIFO entries; power of two, minimum 2.
- TURNS_W, 8: width of the two's-complement revolution counter.

- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- cnt_in  in  4  counter dout sample.
- load_in  in  1  1 = cnt_in on this edge results from a load.
- up_down_in  in  1  direction that produced cnt_in; 1 = up, 0 = down.
- turns  out  TURNS_W  signed net revolutions.
- err_jump  out  1  sticky: an unexpected transition was seen.
- err_illegal  out  1  sticky: cnt_in > 11 was seen.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_code  out  3  0 WRAP_UP, 1 WRAP_DOWN, 2 LOAD, 3 JUMP, 4 ILLEGAL.
- evt_value  out  4  cnt_in value that caused the event.

## Operation

- Internal state: prev[3:0], prev_valid, turns, sticky flags, FIFO (DEPTH entries, wr/rd pointers, count).
- Reset: all outputs 0. prev_valid=0 and the FIFO is empty.
- Classification is evaluated every edge, in priority order:
  - If cnt_in > 11: ILLEGAL. err_illegal is set, the event is pushed, and prev_valid is cleared. turns is unchanged.
  - Else if prev_valid=0: prime the tracker. prev=cnt_in, prev_valid=1, no event.
  - Else if load_in=1: LOAD. The event is pushed and turns is unchanged. This applies even if the value equals an expected step.
  - Else if cnt_in==prev: HOLD. No event.
  - Else if up_down_in=1 and cnt_in==prev+1 (prev≤10): STEP_UP. No event.
  - Else if up_down_in=1 and prev==11 and cnt_in==0: WRAP_UP. The event is pushed and turns increments.
  - Else if up_down_in=0 and cnt_in==prev-1 (prev≥1): STEP_DOWN. No event.
  - Else if up_down_in=0 and prev==0 and cnt_in==11: WRAP_DOWN. The event is pushed and turns decrements.
  - Otherwise: JUMP. err_jump is set and the event is pushed.
- For every legal sample, prev is updated to cnt_in.
- turns saturates: it holds at +2^(TURNS_W-1)-1 on further WRAP_UP and at -2^(TURNS_W-1) on further WRAP_DOWN. Saturation is not an error.
- FIFO behaviour:
  - A push occurs on the classifying edge.
  - A pop occurs on an edge where evt_valid && evt_ready.
  - When full, a simultaneous push and pop both succeed, and count is unchanged.
  - When full with no pop, the new event is dropped and ovf is set. Existing entries are untouched.
  - When empty, a pop has no effect.
- Sticky flags clear only on reset.

## Timing

- Input-to-state latency is 1 cycle. The sample captured on edge N updates turns and flags, and makes the event visible on evt_valid/evt_code/evt_value, immediately after edge N.
- evt_code and evt_value are driven from FIFO storage. They must be stable while evt_valid=1 and evt_ready=0.
- evt_valid deasserts after the edge that pops the last entry, unless a push occurs on the same edge.
- Throughput is one event push and one pop per cycle.
- Reset mid-operation:
  - All state clears immediately, asynchronously.
  - Queued events are lost.
  - The first sample after reset release only primes the tracker. A WRAP is never reported on that sample.
- Samples arriving while the FIFO is full still update turns and prev. Only the event record is lost.

## Test plan

- Prime and count up: reset, then feed 9,10,11,0,1 with up=1. Required: one WRAP_UP with value 0, turns=1, no errors.
- Count down across zero: feed 1,0,11,10 with up=0. Required: one WRAP_DOWN with value 11, turns=-1.
- Load and jump: feed 3, load_in=1 with 7, then 2 with up=1 and no load. Required: LOAD with value 7, then JUMP with value 2, err_jump=1, turns unchanged.
- Illegal value and re-prime: feed 5, 13, 0 (up=1). Required: ILLEGAL with value 13, err_illegal=1, the 0 only primes, no WRAP.
- FIFO full and overflow: hold evt_ready=0 and generate 5 wraps. Required: 4 entries held, ovf=1, turns=5. Then push and pop on the same edge while full: count stays at 4, ovf not re-triggered. Draining returns events in push order.
- Saturation and reset: drive 130 WRAP_UPs with ready=1. Required: turns=127. Assert rst mid-stream: turns=0, evt_valid=0, and the first post-reset sample produces no event.
